// File: rtl/filter_pkg.sv
// Shared constants and helpers for the sliding-window filter front end.
package filter_pkg;

    localparam int DEF_K     = 3;
    localparam int DEF_PIX_W = 9;
    localparam int DEF_MAX_W = 1024;
    localparam int DEF_ROW_W = 16;

    // Address width for a depth of v entries; never narrower than 1 bit.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((longint'(1) << i) < longint'(v)) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

    // LSB of tap (r,c) inside the flattened window vector.
    function automatic int tap_idx(input int r, input int c, input int k, input int pw);
        return (r * k + c) * pw;
    endfunction

endpackage

// File: rtl/window_filter_unit_line_buffer.sv
// Single-port read-first line store; read is combinational so the old word
// is seen in the same cycle that the new one is written.
module line_buffer
    import filter_pkg::*;
#(
    parameter int PIX_W = DEF_PIX_W,
    parameter int DEPTH = DEF_MAX_W
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [clog2(DEPTH)-1:0]  addr_i,
    input  logic [PIX_W-1:0]         wdata_i,
    output logic [PIX_W-1:0]         rdata_o
);

    logic [PIX_W-1:0] mem_q [DEPTH];

    assign rdata_o = mem_q[addr_i];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[addr_i] <= wdata_i;
    end

endmodule

// File: rtl/window_filter_unit.sv
// KxK sliding-window generator with stall, sof resync and position tracking.
// Define WINDOW_BORDER_ZERO_EN for full-width windows with wrapped taps zeroed.
module window_filter_unit
    import filter_pkg::*;
#(
    parameter int K     = DEF_K,
    parameter int PIX_W = DEF_PIX_W,
    parameter int MAX_W = DEF_MAX_W,
    parameter int ROW_W = DEF_ROW_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     refresh,
    input  logic [31:0]              image_width,
    input  logic [PIX_W-1:0]         pix_in,
    input  logic                     pix_valid,
    input  logic                     sof,
    output logic [K*K*PIX_W-1:0]     win_out,
    output logic                     win_valid,
    output logic [clog2(MAX_W)-1:0]  win_col,
    output logic [ROW_W-1:0]         win_row,
    output logic                     cfg_err
);

    localparam int               COL_W   = clog2(MAX_W);
    localparam logic [ROW_W-1:0] ROW_MAX = '1;
    localparam logic [COL_W-1:0] EDGE_C  = COL_W'(K - 1);
    localparam logic [ROW_W-1:0] EDGE_R  = ROW_W'(K - 1);

    logic             clr;
    logic             accept;
    logic             width_bad;
    logic [COL_W-1:0] width_last;

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] last_q, last_d;
    logic             cfg_err_q, cfg_err_d;
    logic             win_valid_q, win_valid_d;
    logic [COL_W-1:0] win_col_q, win_col_d;
    logic [ROW_W-1:0] win_row_q, win_row_d;

    logic [COL_W-1:0] pcol;
    logic [ROW_W-1:0] prow;
    logic [COL_W-1:0] last_eff;

    logic [PIX_W-1:0] vcol  [K];
    logic [PIX_W-1:0] tap_q [K][K];

    assign clr    = rst | refresh;
    assign accept = pix_valid & ~clr;

    // Out-of-range widths fall back to the full line-buffer depth.
    always_comb begin
        width_bad  = (image_width == 32'd0) || (image_width > 32'(MAX_W));
        width_last = width_bad ? COL_W'(MAX_W - 1) : COL_W'(image_width - 32'd1);
    end

    // An accepted sof pixel is placed at (0,0) under the freshly latched width.
    always_comb begin
        pcol        = sof ? '0 : col_q;
        prow        = sof ? '0 : row_q;
        last_eff    = sof ? width_last : last_q;
        col_d       = col_q;
        row_d       = row_q;
        last_d      = last_q;
        cfg_err_d   = cfg_err_q;
        win_valid_d = 1'b0;
        win_col_d   = win_col_q;
        win_row_d   = win_row_q;
        if (accept) begin
            last_d    = last_eff;
            cfg_err_d = cfg_err_q | (sof & width_bad);
            win_col_d = pcol;
            win_row_d = prow;
`ifdef WINDOW_BORDER_ZERO_EN
            win_valid_d = (prow >= EDGE_R);
`else
            win_valid_d = (prow >= EDGE_R) && (pcol >= EDGE_C);
`endif
            if (pcol == last_eff) begin
                col_d = '0;
                row_d = (prow == ROW_MAX) ? prow : prow + 1'b1;
            end else begin
                col_d = pcol + 1'b1;
                row_d = prow;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            col_q       <= '0;
            row_q       <= '0;
            last_q      <= width_last;
            cfg_err_q   <= width_bad;
            win_valid_q <= 1'b0;
            win_col_q   <= '0;
            win_row_q   <= '0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            last_q      <= last_d;
            cfg_err_q   <= cfg_err_d;
            win_valid_q <= win_valid_d;
            win_col_q   <= win_col_d;
            win_row_q   <= win_row_d;
        end
    end

    // Buffer i holds the row i+1 above the current one; each buffer passes its
    // old word down the cascade as the new column vector is formed.
    assign vcol[0] = pix_in;

    for (genvar i = 0; i < K - 1; i++) begin : g_lb
        line_buffer #(
            .PIX_W (PIX_W),
            .DEPTH (MAX_W)
        ) u_lb (
            .clk     (clk),
            .we_i    (accept),
            .addr_i  (pcol),
            .wdata_i (vcol[i]),
            .rdata_o (vcol[i+1])
        );
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) tap_q[r][c] <= '0;
            end
        end else if (pix_valid) begin
            for (int r = 0; r < K; r++) begin
                tap_q[r][0] <= vcol[r];
                for (int c = 1; c < K; c++) tap_q[r][c] <= tap_q[r][c-1];
            end
        end
    end

    for (genvar r = 0; r < K; r++) begin : g_row
        for (genvar c = 0; c < K; c++) begin : g_col
`ifdef WINDOW_BORDER_ZERO_EN
            // Columns left of the line start would come from the previous line.
            assign win_out[tap_idx(r, c, K, PIX_W) +: PIX_W] =
                (win_col_q < COL_W'(c)) ? '0 : tap_q[r][c];
`else
            assign win_out[tap_idx(r, c, K, PIX_W) +: PIX_W] = tap_q[r][c];
`endif
        end
    end

    assign win_valid = win_valid_q;
    assign win_col   = win_col_q;
    assign win_row   = win_row_q;
    assign cfg_err   = cfg_err_q;

endmodule
